cpu_control_fsm: RTL
====================

// Module: cpu_control_fsm
// PURPOSE
//  Multi-cycle RV32I control sequencer. Consumes instruction_decoder fields
//  (opcode, funct3) plus ALU compare result. Drives the strobes that move an
//  instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK on a shared memory
//  port with a ready handshake. Counts retired instructions.
// PARAMETERS
//  RETIRE_W    32  width of instret counter (wraps modulo 2^RETIRE_W)
//  WAIT_LIMIT  16  max cycles mem_req may wait for mem_ready before bus_err; 0 = unlimited
// PORTS
//  clk          in   1   system clock, all state updates on rising edge
//  rst          in   1   synchronous, active-high reset
//  opcode       in   7   decoder opcode (valid from DECODE onward)
//  funct3       in   3   decoder funct3 (loads/stores pass through to mem_size)
//  branch_taken in   1   ALU compare result, sampled in EXECUTE
//  mem_ready    in   1   memory completes current request this cycle
//  mem_req      out  1   memory request strobe, held until mem_ready
//  mem_we       out  1   write request (stores only, valid with mem_req)
//  mem_addr_sel out  1   0 = PC (fetch), 1 = ALU result (load/store)
//  ir_we        out  1   load instruction register
//  alu_src_b    out  1   0 = rs2, 1 = imm
//  reg_we       out  1   register-file write enable
//  wb_sel       out  2   0 = ALU, 1 = mem data, 2 = PC+4, 3 = imm (LUI)
//  pc_we        out  1   PC update strobe
//  pc_src       out  2   0 = PC+4, 1 = PC+imm, 2 = {ALU[31:1],1'b0}
//  retire       out  1   1-cycle pulse when an instruction completes
//  instret      out  RETIRE_W  retired-instruction count
//  halted       out  1   sticky: ECALL/EBREAK seen
//  bus_err      out  1   sticky: WAIT_LIMIT exceeded
//  state        out  3   current state (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 TRAP=6.
//  Outputs are decoded from the registered state and opcode (Moore).
//  Reset: while rst=1 every output is forced 0; next state is FETCH; instret,
//   halted and bus_err clear; the wait counter clears. Reset in any state,
//   including mid-handshake, abandons the request with no PC/reg write.
//  FETCH: mem_req=1, mem_addr_sel=0; on mem_ready: ir_we=1 -> DECODE, else stay.
//  DECODE: 1 cycle, no strobes -> EXEC.
//  EXEC, by opcode:
//   OP 0110011 / OP-IMM 0010011 / LUI 0110111 / AUIPC 0010111 -> WB.
//   LOAD 0000011 / STORE 0100011: alu_src_b=1 -> MEM.
//   BRANCH 1100011: pc_we=1, pc_src = branch_taken ? 1 : 0, retire -> FETCH.
//   JAL 1101111 / JALR 1100111 -> WB.
//   MISC-MEM 0001111 (FENCE): NOP, pc_we=1, pc_src=0, retire -> FETCH.
//   SYSTEM 1110011: -> HALT (no PC update, no retire).
//   Any other opcode: see CONFIGURATION.
//  MEM: mem_req=1, mem_addr_sel=1, mem_we = STORE. On mem_ready: load -> WB;
//   store -> pc_we=1, pc_src=0, retire -> FETCH.
//  WB: reg_we=1, pc_we=1, retire -> FETCH. wb_sel: OP/OP-IMM/AUIPC=0, LOAD=1,
//   JAL/JALR=2, LUI=3. pc_src: JAL=1, JALR=2, else 0.
//  Wait counter: counts consecutive mem_req cycles with mem_ready=0; if it
//   reaches WAIT_LIMIT (nonzero), set bus_err, drop mem_req -> TRAP.
//   Counter clears on every mem_ready and every state change.
//  HALT/TRAP: all strobes 0, stay until rst.
//  Latency with mem_ready=1: ALU/LUI/AUIPC/JAL(R) 4 cycles, load 5, store 4,
//   branch/FENCE 3. Each mem_ready stall adds one cycle.
//  retire and instret increment occur in the same cycle; instret wraps.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: an unrecognised opcode in EXEC goes to TRAP and
//   holds; no retire, no PC update; halted stays 0.
//  Not defined: an unrecognised opcode is a NOP: pc_we=1, pc_src=0, retire,
//   -> FETCH.
// TESTING
//  ADDI 0x00750193, mem_ready=1 -> states 0,1,2,4; reg_we/pc_we/retire on
//   cycle 4 with wb_sel=0; instret=1.
//  LW 0x00452183, mem_ready low 3 cycles in MEM -> mem_req held, mem_we=0;
//   WB on cycle 8, wb_sel=1.
//  SW 0x005520A3 -> MEM asserts mem_we=1, mem_addr_sel=1; retire in MEM;
//   reg_we never asserts.
//  BEQ, branch_taken=1 then 0 -> pc_src=1 then 0, each retiring in EXEC (cycle 3).
//  JAL 0x010001EF / JALR -> WB with wb_sel=2, pc_src=1 / 2.
//  Faults and reset: opcode 0x7F retires as a NOP without ILLEGAL_TRAP_EN and
//   goes to TRAP with it. mem_ready=0 for 16 cycles -> bus_err=1, TRAP.
//   ECALL -> halted=1. rst pulsed in MEM -> all outputs 0, FETCH, instret=0.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle RV32I control sequencer FETCH/DECODE/EXEC/MEM/WB with memory handshake
// Ports: clk, rst (sync, active high); opcode, funct3, branch_taken, mem_ready in;
//   mem_req, mem_we, mem_addr_sel, ir_we, alu_src_b, reg_we, wb_sel, pc_we, pc_src,
//   retire, instret, halted, bus_err, state out.
// Macro ILLEGAL_TRAP_EN: unrecognised opcodes trap instead of retiring as NOPs.
module cpu_control_fsm #(
  parameter int RETIRE_W   = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                branch_taken,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                ir_we,
  output logic                alu_src_b,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                retire,
  output logic [RETIRE_W-1:0] instret,
  output logic                halted,
  output logic                bus_err,
  output logic [2:0]          state
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;
  localparam logic [31:0] WL = WAIT_LIMIT;
  state_t st;
  logic [RETIRE_W-1:0] cnt;
  logic halt_r, err_r;
  logic [31:0] wcnt;
  logic op_ld, op_st, op_br, op_fence, op_sys, op_jal, op_jalr, op_lui, op_wb, op_other, ill_nop;
  logic mem_phase, timeout;
  logic unused_funct3;
  assign unused_funct3 = ^funct3;
  assign op_ld     = opcode == 7'b0000011;
  assign op_st     = opcode == 7'b0100011;
  assign op_br     = opcode == 7'b1100011;
  assign op_fence  = opcode == 7'b0001111;
  assign op_sys    = opcode == 7'b1110011;
  assign op_jal    = opcode == 7'b1101111;
  assign op_jalr   = opcode == 7'b1100111;
  assign op_lui    = opcode == 7'b0110111;
  assign op_wb     = op_jal || op_jalr || op_lui || opcode inside {7'b0110011, 7'b0010011, 7'b0010111};
  assign op_other  = !(op_wb || op_ld || op_st || op_br || op_fence || op_sys);
`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = TRAP;
  assign ill_nop = 1'b0;
`else
  localparam state_t ILL_NEXT = FETCH;
  assign ill_nop = op_other;
`endif
  // The wait counter only runs while a request is outstanding; limit 0 disables the timeout.
  assign mem_phase = st == FETCH || st == MEM;
  assign timeout   = mem_phase && !mem_ready && WL != 32'd0 && wcnt == WL - 32'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= FETCH;
      cnt    <= '0;
      halt_r <= 1'b0;
      err_r  <= 1'b0;
      wcnt   <= '0;
    end else begin
      if (retire) cnt <= cnt + 1'b1;
      wcnt <= (mem_phase && !mem_ready && WL != 32'd0 && !timeout) ? wcnt + 32'd1 : '0;
      if (st == EXEC && op_sys) halt_r <= 1'b1;
      if (timeout) begin
        err_r <= 1'b1;
        st    <= TRAP;
      end else begin
        case (st)
          FETCH:   if (mem_ready) st <= DECODE;
          DECODE:  st <= EXEC;
          EXEC:    st <= op_wb ? WB : (op_ld || op_st) ? MEM : (op_br || op_fence) ? FETCH :
                         op_sys ? HALT : op_other ? ILL_NEXT : FETCH;
          MEM:     if (mem_ready) st <= op_ld ? WB : FETCH;
          WB:      st <= FETCH;
          default: st <= st;
        endcase
      end
    end
  end
  // Strobes are decoded from the registered state; reset forces every output low at once.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    alu_src_b    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    retire       = 1'b0;
    if (!rst) begin
      case (st)
        FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        EXEC: begin
          alu_src_b = op_ld || op_st;
          pc_we     = op_br || op_fence || ill_nop;
          pc_src    = (op_br && branch_taken) ? 2'd1 : 2'd0;
          retire    = op_br || op_fence || ill_nop;
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = op_st;
          pc_we        = op_st && mem_ready;
          retire       = op_st && mem_ready;
        end
        WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          wb_sel = op_ld ? 2'd1 : (op_jal || op_jalr) ? 2'd2 : op_lui ? 2'd3 : 2'd0;
          pc_src = op_jal ? 2'd1 : op_jalr ? 2'd2 : 2'd0;
        end
        default: ;
      endcase
    end
  end
  assign instret = rst ? '0 : cnt;
  assign halted  = !rst && halt_r;
  assign bus_err = !rst && err_r;
  assign state   = rst ? 3'd0 : st;
endmodule
